// File: rtl/integral_row_writer_pkg.sv
// Shared widths, state encoding and default frame geometry for the integral row writer.
// Also provides the window-reduction negation helper.
package integral_row_writer_pkg;

  localparam int DATA_WIDTH_8  = 8;
  localparam int DATA_WIDTH_16 = 16;
  localparam int ADDR_WIDTH    = 12;

  localparam int INTEGRAL_WIDTH_DEF      = 3;
  localparam int FRAME_CAMERA_WIDTH_DEF  = 10;
  localparam int FRAME_CAMERA_HEIGHT_DEF = 8;

  typedef logic [DATA_WIDTH_8-1:0]  pixel_t;
  typedef logic [DATA_WIDTH_16-1:0] sum_t;
  typedef logic [ADDR_WIDTH-1:0]    addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FDONE  = 2'd2
  } state_t;

  // Two's-complement negation of a zero-extended pixel, modulo 2^16.
  function automatic sum_t negate(input pixel_t p);
    return sum_t'(16'h0 - {8'h0, p});
  endfunction

endpackage

// File: rtl/integral_row_writer_if.sv
// Pixel-in / row-stage-out bundle between the camera front-end, the writer and the row stage.
// master = stream source / row-stage side, slave = integral_row_writer.
interface integral_row_writer_if;
  import integral_row_writer_pkg::*;

  pixel_t i_pixel;
  logic   i_pixel_valid;
  logic   i_sof;
  logic   i_row_fill;
  logic   o_ready;
  logic   o_wen;
  sum_t   o_fifo_in;
  sum_t   o_reduction_sum;
  addr_t  o_col;
  addr_t  o_row;
  logic   o_eol;
  logic   o_eof;
  logic   o_error;

  modport master (
    output i_pixel, i_pixel_valid, i_sof, i_row_fill,
    input  o_ready, o_wen, o_fifo_in, o_reduction_sum, o_col, o_row, o_eol, o_eof, o_error
  );

  modport slave (
    input  i_pixel, i_pixel_valid, i_sof, i_row_fill,
    output o_ready, o_wen, o_fifo_in, o_reduction_sum, o_col, o_row, o_eol, o_eof, o_error
  );

endinterface

// File: rtl/integral_row_writer_pixel_window_shift.sv
// DEPTH x 8-bit pixel shift register with synchronous clear; o_oldest taps the entry
// that was shifted in DEPTH pixels ago.
module pixel_window_shift
  import integral_row_writer_pkg::*;
#(
  parameter int DEPTH = INTEGRAL_WIDTH_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_shift,
  input  logic   i_clear,
  input  pixel_t i_pixel,
  output pixel_t o_oldest
);

  logic [DEPTH-1:0][DATA_WIDTH_8-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (i_shift) begin
      // A clear still loads the incoming pixel so it becomes column 0 of the new line.
      if (i_clear) begin
        win_d    = '0;
        win_d[0] = i_pixel;
      end else begin
        win_d = {win_q[DEPTH-2:0], i_pixel};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) win_q <= '0;
    else       win_q <= win_d;
  end

  assign o_oldest = win_q[DEPTH-1];

endmodule

// File: rtl/integral_row_writer.sv
// Producer side of the integral row line buffer: turns the camera pixel stream into write
// strobes, line-cumulative sums and window-reduction terms, and tracks frame position.
//
// state  | meaning
// IDLE   | waiting for a pixel qualified with i_sof
// ACTIVE | inside a frame, counting columns and rows
// FDONE  | last pixel of the frame written; not ready for one cycle
module integral_row_writer
  import integral_row_writer_pkg::*;
#(
  parameter int INTEGRAL_WIDTH      = INTEGRAL_WIDTH_DEF,
  parameter int FRAME_CAMERA_WIDTH  = FRAME_CAMERA_WIDTH_DEF,
  parameter int FRAME_CAMERA_HEIGHT = FRAME_CAMERA_HEIGHT_DEF
) (
  input logic                  clk,
  input logic                  reset,
  integral_row_writer_if.slave bus
);

  localparam addr_t LAST_COL = addr_t'(FRAME_CAMERA_WIDTH - 1);
  localparam addr_t LAST_ROW = addr_t'(FRAME_CAMERA_HEIGHT - 1);
  localparam addr_t WIN_LEN  = addr_t'(INTEGRAL_WIDTH);

  state_t state_q, state_d;
  addr_t  col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
  logic   wen_q, wen_d, eol_q, eol_d, eof_q, eof_d, error_q, error_d;
  sum_t   fifo_in_q, fifo_in_d, red_q, red_d;
  addr_t  col_q, col_d, row_q, row_d;

  logic   ready, accept, restart, take, is_eol, is_eof;
  addr_t  pix_col, pix_row;
  pixel_t oldest;

  assign ready   = (state_q != FDONE);
  assign accept  = bus.i_pixel_valid & ready;
  assign restart = accept & bus.i_sof;
  assign take    = accept & (bus.i_sof | (state_q == ACTIVE));
  assign pix_col = restart ? '0 : col_cnt_q;
  assign pix_row = restart ? '0 : row_cnt_q;
  assign is_eol  = (pix_col == LAST_COL);
  assign is_eof  = is_eol & (pix_row == LAST_ROW);

  pixel_window_shift #(.DEPTH(INTEGRAL_WIDTH)) u_window (
    .clk      (clk),
    .reset    (reset),
    .i_shift  (take),
    .i_clear  (pix_col == '0),
    .i_pixel  (bus.i_pixel),
    .o_oldest (oldest)
  );

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    wen_d     = 1'b0;
    fifo_in_d = fifo_in_q;
    red_d     = red_q;
    col_d     = col_q;
    row_d     = row_q;
    eol_d     = eol_q;
    eof_d     = eof_q;
    // Row fill is only legal on the cycle right after an end-of-line write.
    error_d   = (restart & (state_q == ACTIVE)) | (bus.i_row_fill & ~(wen_q & eol_q));

    case (state_q)
      IDLE, ACTIVE: if (take) state_d = is_eof ? FDONE : ACTIVE;
      FDONE:        state_d = IDLE;
      default:      state_d = IDLE;
    endcase

    if (take) begin
      wen_d     = 1'b1;
      col_d     = pix_col;
      row_d     = pix_row;
      eol_d     = is_eol;
      eof_d     = is_eof;
      fifo_in_d = ((pix_col == '0) ? sum_t'(0) : fifo_in_q) + sum_t'(bus.i_pixel);
      red_d     = (pix_col >= WIN_LEN) ? negate(oldest) : sum_t'(0);
      col_cnt_d = is_eol ? '0 : addr_t'(pix_col + 1'b1);
      row_cnt_d = is_eof ? '0 : (is_eol ? addr_t'(pix_row + 1'b1) : pix_row);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      wen_q     <= 1'b0;
      fifo_in_q <= '0;
      red_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      wen_q     <= wen_d;
      fifo_in_q <= fifo_in_d;
      red_q     <= red_d;
      col_q     <= col_d;
      row_q     <= row_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      error_q   <= error_d;
    end
  end

  assign bus.o_ready         = ready;
  assign bus.o_wen           = wen_q;
  assign bus.o_fifo_in       = fifo_in_q;
  assign bus.o_reduction_sum = red_q;
  assign bus.o_col           = col_q;
  assign bus.o_row           = row_q;
  assign bus.o_eol           = eol_q;
  assign bus.o_eof           = eof_q;
  assign bus.o_error         = error_q;

endmodule

// File: tb/tb_integral_row_writer.sv
// Scoreboard bench: directed pixel vectors push hand-computed expected writes into queues,
// monitors pop and compare whenever a DUT raises o_wen.
module tb_integral_row_writer;
  import integral_row_writer_pkg::*;

  typedef struct packed {
    logic [15:0] fifo;
    logic [15:0] red;
    logic [11:0] col;
    logic [11:0] row;
    logic        eol;
    logic        eof;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pushed_a = 0, pushed_b = 0, wen_a = 0, wen_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  integral_row_writer_if ifa ();
  integral_row_writer_if ifb ();

  integral_row_writer #(.INTEGRAL_WIDTH(3), .FRAME_CAMERA_WIDTH(4), .FRAME_CAMERA_HEIGHT(2))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  integral_row_writer #(.INTEGRAL_WIDTH(3), .FRAME_CAMERA_WIDTH(300), .FRAME_CAMERA_HEIGHT(2))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  function automatic exp_t mk(input logic [15:0] f, input logic [15:0] r, input int c, input int rw,
                              input logic eol, input logic eof, input logic err);
    exp_t e;
    e.fifo = f; e.red = r; e.col = 12'(c); e.row = 12'(rw);
    e.eol = eol; e.eof = eof; e.err = err;
    return e;
  endfunction

  function automatic exp_t got_of(input logic [15:0] f, input logic [15:0] r, input logic [11:0] c,
                                  input logic [11:0] rw, input logic eol, input logic eof,
                                  input logic err);
    return mk(f, r, int'(c), int'(rw), eol, eof, err);
  endfunction

  always @(negedge clk) begin
    if (ifa.o_wen === 1'b1) begin
      wen_a++;
      if (q_a.size() == 0) check("txn_a_unexpected", 64'(ifa.o_fifo_in), 64'hDEAD);
      else check("txn_a", 64'(got_of(ifa.o_fifo_in, ifa.o_reduction_sum, ifa.o_col, ifa.o_row,
                                     ifa.o_eol, ifa.o_eof, ifa.o_error)), 64'(q_a.pop_front()));
    end
    if (ifb.o_wen === 1'b1) begin
      wen_b++;
      if (q_b.size() == 0) check("txn_b_unexpected", 64'(ifb.o_fifo_in), 64'hDEAD);
      else check("txn_b", 64'(got_of(ifb.o_fifo_in, ifb.o_reduction_sum, ifb.o_col, ifb.o_row,
                                     ifb.o_eol, ifb.o_eof, ifb.o_error)), 64'(q_b.pop_front()));
    end
  end

  task automatic send_a(input logic [7:0] p, input logic sof, input logic rf, input logic push,
                        input exp_t e);
    ifa.i_pixel = p; ifa.i_pixel_valid = 1'b1; ifa.i_sof = sof; ifa.i_row_fill = rf;
    if (push) begin q_a.push_back(e); pushed_a++; end
    @(posedge clk); #1;
    ifa.i_pixel_valid = 1'b0; ifa.i_sof = 1'b0; ifa.i_row_fill = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] p, input logic sof, input exp_t e);
    ifb.i_pixel = p; ifb.i_pixel_valid = 1'b1; ifb.i_sof = sof; ifb.i_row_fill = 1'b0;
    q_b.push_back(e); pushed_b++;
    @(posedge clk); #1;
    ifb.i_pixel_valid = 1'b0; ifb.i_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame_1to8(input bit gaps);
    send_a(1, 1, 0, 1, mk(1, 0, 0, 0, 0, 0, 0));      if (gaps) idle(1);
    send_a(2, 0, 0, 1, mk(3, 0, 1, 0, 0, 0, 0));      if (gaps) idle(1);
    send_a(3, 0, 0, 1, mk(6, 0, 2, 0, 0, 0, 0));      if (gaps) idle(1);
    if (gaps) begin
      check("gap_hold_fifo", 64'(ifa.o_fifo_in), 64'd6);
      check("gap_hold_col", 64'(ifa.o_col), 64'd2);
      check("gap_no_wen", 64'(ifa.o_wen), 64'd0);
    end
    send_a(4, 0, 0, 1, mk(10, 16'hFFFF, 3, 0, 1, 0, 0)); if (gaps) idle(1);
    send_a(5, 0, !gaps, 1, mk(5, 0, 0, 1, 0, 0, 0));  if (gaps) idle(1);
    send_a(6, 0, !gaps, 1, mk(11, 0, 1, 1, 0, 0, !gaps)); if (gaps) idle(1);
    send_a(7, 0, 0, 1, mk(18, 0, 2, 1, 0, 0, 0));     if (gaps) idle(1);
    send_a(8, 0, 0, 1, mk(26, 16'hFFFB, 3, 1, 1, 1, 0));
  endtask

  initial begin
    ifa.i_pixel = '0; ifa.i_pixel_valid = 0; ifa.i_sof = 0; ifa.i_row_fill = 0;
    ifb.i_pixel = '0; ifb.i_pixel_valid = 0; ifb.i_sof = 0; ifb.i_row_fill = 0;
    #1 reset = 1'b1;
    #1;
    check("rst_fifo", 64'(ifa.o_fifo_in), 64'd0);
    check("rst_wen", 64'(ifa.o_wen), 64'd0);
    check("rst_ready", 64'(ifa.o_ready), 64'd1);
    check("rst_colrow", 64'({ifa.o_col, ifa.o_row}), 64'd0);
    @(posedge clk); #1; @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // Full frame back to back, row-fill legal on pixel 5 and illegal on pixel 6.
    frame_1to8(1'b0);
    check("fdone_not_ready", 64'(ifa.o_ready), 64'd0);
    idle(1);
    check("ready_after_fdone", 64'(ifa.o_ready), 64'd1);

    // Dropped pixel in IDLE, then the same frame with a gap between every pixel.
    send_a(99, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    check("idle_drop_no_wen", 64'(ifa.o_wen), 64'd0);
    frame_1to8(1'b1);
    idle(1);

    // Mid-frame sof restarts the frame at (0,0) and flags an error.
    send_a(10, 1, 0, 1, mk(10, 0, 0, 0, 0, 0, 0));
    send_a(20, 0, 0, 1, mk(30, 0, 1, 0, 0, 0, 0));
    send_a(30, 1, 0, 1, mk(30, 0, 0, 0, 0, 0, 1));
    send_a(40, 0, 0, 1, mk(70, 0, 1, 0, 0, 0, 0));
    send_a(50, 0, 0, 1, mk(120, 0, 2, 0, 0, 0, 0));
    send_a(60, 0, 0, 1, mk(180, 16'hFFE2, 3, 0, 1, 0, 0));
    send_a(7, 0, 0, 1, mk(7, 0, 0, 1, 0, 0, 0));
    idle(1);

    // Reset in the middle of line 1, then a fresh frame needs sof.
    reset = 1'b1;
    #1;
    check("midrst_fifo", 64'(ifa.o_fifo_in), 64'd0);
    check("midrst_colrow", 64'({ifa.o_col, ifa.o_row}), 64'd0);
    check("midrst_ready", 64'(ifa.o_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    send_a(9, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    send_a(3, 1, 0, 1, mk(3, 0, 0, 0, 0, 0, 0));
    send_a(4, 0, 0, 1, mk(7, 0, 1, 0, 0, 0, 0));
    idle(2);

    // Wide line of 255s: 255*257 = 65535 at col 256, wraps to 254 at col 257.
    for (int c = 0; c < 258; c++)
      send_b(8'd255, c == 0, mk(16'(255 * (c + 1)), (c >= 3) ? 16'hFF01 : 16'h0, c, 0, 0, 0, 0));
    idle(2);

    check("q_a_empty", 64'(q_a.size()), 64'd0);
    check("q_b_empty", 64'(q_b.size()), 64'd0);
    check("wen_count_a", 64'(wen_a), 64'(pushed_a));
    check("wen_count_b", 64'(wen_b), 64'(pushed_b));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
